// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the push-button conditioning block.
//   - FSM state encodings used by every button channel (3 bits).
//   - Button index constants matching the bit order of the button buses.
//   - A helper that sizes a counter for a set of terminal counts.
// -----------------------------------------------------------------------------
package button_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_DB_PRESS   = 3'd1;
  localparam logic [2:0] ST_HELD       = 3'd2;
  localparam logic [2:0] ST_REPEAT     = 3'd3;
  localparam logic [2:0] ST_DB_RELEASE = 3'd4;

  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_M = 4;

  // Width able to hold any value 0..max(a,b)-1, never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One push-button channel: 2-flop synchroniser, debounce FSM with a stable-
// cycle counter, and an auto-repeat counter.
//
// Ports
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_raw      raw asynchronous button level (active-high)
//   i_rep_en   auto-repeat enable, sampled every cycle
//   o_level    debounced level (1 in HELD, REPEAT, DB_RELEASE)
//   o_press    1-cycle pulse when a press is accepted
//   o_release  1-cycle pulse when a release is accepted
//   o_repeat   1-cycle pulse on an accepted press and on each repeat tick
//
// All outputs are flops loaded from the next-state/next-output logic, so
// there is no combinational path from i_raw to any output.
// -----------------------------------------------------------------------------
module button_channel
  import button_pkg::*;
#(
  parameter int DB_CNT    = 1000000,
  parameter int REP_DELAY = 50000000,
  parameter int REP_RATE  = 10000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  input  logic i_rep_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int DB_W  = cnt_width(DB_CNT, DB_CNT);
  localparam int REP_W = cnt_width(REP_DELAY, REP_RATE);

  // The sample that moves the FSM out of IDLE (or HELD/REPEAT) is itself the
  // first stable cycle, so the debounce counter terminates one value early.
  // This is why DB_CNT must be at least 2.
  localparam logic [DB_W-1:0]  DB_TERM       = DB_W'(DB_CNT - 2);
  localparam logic [REP_W-1:0] REP_DLY_TERM  = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RATE_TERM = REP_W'(REP_RATE - 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic [2:0]       r_state;
  logic [DB_W-1:0]  r_db_cnt;
  logic [REP_W-1:0] r_rep_cnt;

  logic [2:0]       w_state_nxt;
  logic [DB_W-1:0]  w_db_nxt;
  logic [REP_W-1:0] w_rep_nxt;
  logic             w_s2;
  logic             w_db_done;
  logic             w_dly_done;
  logic             w_rate_done;
  logic             w_level_nxt;
  logic             w_press_nxt;
  logic             w_release_nxt;
  logic             w_repeat_nxt;

  // Stage p0/p1: two-flop synchroniser; the FSM only ever sees r_sync_p1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= i_raw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_s2        = r_sync_p1;
  assign w_db_done   = (r_db_cnt == DB_TERM);
  assign w_dly_done  = (r_rep_cnt == REP_DLY_TERM);
  assign w_rate_done = (r_rep_cnt == REP_RATE_TERM);

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_db_cnt  <= '0;
      r_rep_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_db_cnt  <= w_db_nxt;
      r_rep_cnt <= w_rep_nxt;
    end
  end

  // Next-state and counter update.
  always_comb begin
    w_state_nxt = r_state;
    w_db_nxt    = r_db_cnt;
    w_rep_nxt   = r_rep_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_s2) begin
          w_state_nxt = ST_DB_PRESS;
          w_db_nxt    = '0;
        end
      end
      ST_DB_PRESS: begin
        if (!w_s2) begin
          w_state_nxt = ST_IDLE;
        end else if (w_db_done) begin
          w_state_nxt = ST_HELD;
          w_rep_nxt   = '0;
        end else begin
          w_db_nxt = r_db_cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!w_s2) begin
          w_state_nxt = ST_DB_RELEASE;
          w_db_nxt    = '0;
        end else if (i_rep_en && w_dly_done) begin
          w_state_nxt = ST_REPEAT;
          w_rep_nxt   = '0;
        end else if (!w_dly_done) begin
          // Holds at the delay terminal while repeat is disabled, so enabling
          // it later fires on the very next cycle.
          w_rep_nxt = r_rep_cnt + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!w_s2) begin
          w_state_nxt = ST_DB_RELEASE;
          w_db_nxt    = '0;
        end else if (w_rate_done) begin
          w_rep_nxt = '0;
        end else begin
          w_rep_nxt = r_rep_cnt + 1'b1;
        end
      end
      ST_DB_RELEASE: begin
        if (w_s2) begin
          // Release bounce: back to HELD and restart the repeat delay.
          w_state_nxt = ST_HELD;
          w_rep_nxt   = '0;
        end else if (w_db_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_db_nxt = r_db_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_db_nxt    = '0;
        w_rep_nxt   = '0;
      end
    endcase
  end

  // Output decode; evaluated one cycle ahead and registered below.
  always_comb begin
    w_press_nxt   = (r_state == ST_DB_PRESS) && w_s2 && w_db_done;
    w_release_nxt = (r_state == ST_DB_RELEASE) && !w_s2 && w_db_done;
    w_repeat_nxt  = w_press_nxt
                  | ((r_state == ST_HELD)   && w_s2 && i_rep_en && w_dly_done)
                  | ((r_state == ST_REPEAT) && w_s2 && i_rep_en && w_rate_done);
    w_level_nxt   = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_REPEAT) ||
                    (w_state_nxt == ST_DB_RELEASE);
  end

  // Output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_repeat  <= 1'b0;
    end else begin
      o_level   <= w_level_nxt;
      o_press   <= w_press_nxt;
      o_release <= w_release_nxt;
      o_repeat  <= w_repeat_nxt;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions the raw board push buttons (bit order u, d, l, r, m) for the
// clock, alarm, stopwatch and game services. Each bit is an independent
// button_channel; there is no interaction between channels.
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   btn_raw      raw asynchronous button levels (active-high)
//   repeat_en    per-button auto-repeat enable
//   btn_level    debounced levels
//   btn_press    1-cycle pulse per accepted press
//   btn_release  1-cycle pulse per accepted release
//   btn_repeat   1-cycle pulse per accepted press and per repeat tick
//   any_active   OR of btn_level
// -----------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN     = 5,
  parameter int DB_CNT    = 1000000,
  parameter int REP_DELAY = 50000000,
  parameter int REP_RATE  = 10000000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_active
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    button_channel #(
      .DB_CNT    (DB_CNT),
      .REP_DELAY (REP_DELAY),
      .REP_RATE  (REP_RATE)
    ) u_ch (
      .i_clk     (clk),
      .i_rst_n   (resetn),
      .i_raw     (btn_raw[g]),
      .i_rep_en  (repeat_en[g]),
      .o_level   (btn_level[g]),
      .o_press   (btn_press[g]),
      .o_release (btn_release[g]),
      .o_repeat  (btn_repeat[g])
    );
  end

  // Driven only by the registered levels, so it never sees btn_raw directly.
  assign any_active = |btn_level;

endmodule
